// File: rtl/common_types_pkg.sv
// Shared types for the execute-stage multiplier: operand word type and sequencer states.
package common_types_pkg;

    localparam int MULT_W = 32;

    typedef logic [MULT_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_seq_dp.sv
// Shift-add datapath for mult_seq: operand magnitudes, 2W accumulator, sign fix-up and result register.
// Under MULT_EARLY_TERM_EN it also flags when the remaining multiplier bits are all zero.
module mult_seq_dp
    import common_types_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_commit,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed_a,
    input  logic             i_signed_b,
    input  logic             i_half,
    output logic             o_exit_early,
    output logic [WIDTH-1:0] o_result
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic               r_half;
    logic [WIDTH-1:0]   r_result;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;

    assign w_a_neg = i_signed_a & i_a[WIDTH-1];
    assign w_b_neg = i_signed_b & i_b[WIDTH-1];
    // The most-negative value maps onto itself, which read unsigned is the correct magnitude.
    assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;

    // The result is taken from the accumulator value this step produces, so it is ready in DONE.
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_prod    = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;

`ifdef MULT_EARLY_TERM_EN
    assign o_exit_early = (r_mplier[WIDTH-1:1] == '0);
`else
    assign o_exit_early = 1'b0;
`endif

    assign o_result = r_result;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_half   <= 1'b0;
            r_result <= '0;
        end else begin
            if (i_load) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                r_mplier <= w_b_mag;
                r_acc    <= '0;
                r_neg    <= w_a_neg ^ w_b_neg;
                r_half   <= i_half;
            end else if (i_step) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
            if (i_commit) begin
                r_result <= r_half ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mult_seq.sv
// Iterative radix-2 RV32M multiplier sequencer: IDLE -> RUN (one bit per cycle) -> DONE.
// Optional MULT_EARLY_TERM_EN ends RUN once no multiplier bits remain.
module mult_seq
    import common_types_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_a,
    input  logic             signed_b,
    input  logic             half,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output mult_state_t      dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);

    mult_state_t      r_state;
    mult_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic             w_load;
    logic             w_step;
    logic             w_commit;
    logic             w_exit_early;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_count <= '0;
            end else if (w_step) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Flush takes priority everywhere; a flushed RUN never commits, so result keeps its value.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !flush) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_count == CNT_W'(WIDTH-1) || w_exit_early) begin
                        w_commit    = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

    mult_seq_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .CLK          (CLK),
        .nRST         (nRST),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_commit     (w_commit),
        .i_a          (a),
        .i_b          (b),
        .i_signed_a   (signed_a),
        .i_signed_b   (signed_b),
        .i_half       (half),
        .o_exit_early (w_exit_early),
        .o_result     (result)
    );

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed RV32M cases, abort paths and randomized operations
// compared against a plain 64-bit arithmetic reference model. Honours MULT_EARLY_TERM_EN for latency.
module tb_mult_seq;
    import common_types_pkg::*;

    localparam int W = 32;

    logic         CLK;
    logic         nRST;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         signed_a;
    logic         signed_b;
    logic         half;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    mult_state_t  dbg_state;

    int           n_checks;
    int           n_fail;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_result;

    mult_seq #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .start     (start),
        .a         (a),
        .b         (b),
        .signed_a  (signed_a),
        .signed_b  (signed_b),
        .half      (half),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rsa, input logic rsb, input logic rh);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] p;
        ea = rsa ? {{32{ra[W-1]}}, ra} : {32'b0, ra};
        eb = rsb ? {{32{rb[W-1]}}, rb} : {32'b0, rb};
        p  = ea * eb;
        return rh ? p[63:32] : p[31:0];
    endfunction

    // Cycle (counting the start cycle as 0) in which done is expected.
    function automatic int ref_lat(input logic [W-1:0] rb, input logic rsb);
`ifdef MULT_EARLY_TERM_EN
        logic [W-1:0] mag;
        int           top;
        mag = (rsb && rb[W-1]) ? -rb : rb;
        top = 0;
        for (int i = 0; i < W; i++) if (mag[i]) top = i;
        return top + 2;
`else
        return W + 1;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Entered and left at a negedge; poke_cyc > 0 issues a stray start in that RUN cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsa,
                          input logic tsb, input logic th, input int poke_cyc);
        int   lat;
        int   exp_lat;
        logic seen;
        logic [W-1:0] exp_r;
        a = ta; b = tb_; signed_a = tsa; signed_b = tsb; half = th; start = 1'b1;
        exp_q.push_back(ref_mul(ta, tb_, tsa, tsb, th));
        exp_lat = ref_lat(tb_, tsb);
        @(posedge CLK);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; signed_a = $urandom_range(0, 1); half = $urandom_range(0, 1);
        seen = 1'b0;
        lat  = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge CLK);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = cyc;
                break;
            end
            if (cyc == poke_cyc) start = 1'b1;
        end
        start = 1'b0;
        exp_r = exp_q.pop_front();
        check("done_seen", seen, 1'b1);
        if (seen) begin
            check("latency", lat, exp_lat);
            check("busy_at_done", busy, 1'b1);
            check("result", result, exp_r);
            last_result = exp_r;
            @(negedge CLK);
            check("idle_after_done", {busy, done}, 2'b00);
        end
    endtask

    task automatic flush_test();
        logic saw_done;
        a = 32'd9; b = 32'hF000_0000; signed_a = 1'b0; signed_b = 1'b0; half = 1'b0; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        saw_done = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge CLK);
            if (done) saw_done = 1'b1;
            if (cyc == 10) flush = 1'b1;
        end
        @(negedge CLK);
        flush = 1'b0;
        check("flush_idle", {busy, done}, 2'b00);
        check("flush_state", dbg_state, IDLE);
        check("flush_result_kept", result, last_result);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (done || busy) saw_done = 1'b1;
        end
        check("flush_no_done", saw_done, 1'b0);
        // start together with flush in IDLE must be dropped
        a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1;
        @(negedge CLK);
        start = 1'b0; flush = 1'b0;
        check("flush_beats_start", busy, 1'b0);
    endtask

    task automatic reset_mid_run();
        a = 32'd77; b = 32'hF000_0001; signed_a = 1'b0; signed_b = 1'b0; half = 1'b0; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) @(negedge CLK);
        check("busy_before_reset", busy, 1'b1);
        #2;
        nRST = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_result", result, '0);
        check("async_rst_state", dbg_state, IDLE);
        last_result = '0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        n_checks = 0; n_fail = 0; last_result = '0;
        nRST = 1'b0; start = 1'b0; flush = 1'b0;
        a = '0; b = '0; signed_a = 1'b0; signed_b = 1'b0; half = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, '0);
        check("reset_state", dbg_state, IDLE);
        nRST = 1'b1;
        @(negedge CLK);

        run_op(32'd7,          32'd6,          1'b0, 1'b0, 1'b0, 0);
        run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 0);
        run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b1, 1'b1, 0);
        run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b1, 1'b0, 0);
        run_op(32'hFFFF_FFFE,  32'd3,          1'b1, 1'b0, 1'b1, 0);
        run_op(32'hFFFF_FFFE,  32'd3,          1'b1, 1'b0, 1'b0, 0);
        run_op(32'd3,          32'h10,         1'b0, 1'b0, 1'b0, 0);
        run_op(32'h1234_5678,  32'd0,          1'b1, 1'b1, 1'b0, 0);
        run_op(32'h8000_0000,  32'h8000_0000,  1'b1, 1'b1, 1'b1, 0);
        run_op(32'h8000_0000,  32'd1,          1'b1, 1'b0, 1'b1, 0);
        run_op(32'd5,          32'hFFFF_FFFD,  1'b0, 1'b1, 1'b1, 0);

        flush_test();

        // stray start during RUN must not disturb the operation in flight
        run_op(32'hDEAD_BEEF,  32'h8000_0001,  1'b0, 1'b0, 1'b0, 5);

        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0);
        end

        reset_mid_run();
        run_op(32'd123_456,    32'd789,        1'b0, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
